alu_issuer: RTL and testbench

ALU_ISSUER -- requirements
Module: alu_issuer

---
 rtl/alu_issuer_if.sv | 28 ++
 rtl/alu_issuer.sv | 100 ++++++++++
 tb/tb_alu_issuer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issuer_if.sv
// Command, ALU-issue and response signals of the accumulator issuer.
// The slave modport is the issuer. The master modport is its environment: command source, ALU and consumer.
interface alu_issuer_if #(
  parameter int N = 32
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_opcode;
  logic [N-1:0] cmd_operand;
  logic [3:0]   alu_opcode;
  logic [N-1:0] alu_op_a;
  logic [N-1:0] alu_op_b;
  logic [N-1:0] alu_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_err;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_operand, alu_result, rsp_ready,
    output cmd_ready, alu_opcode, alu_op_a, alu_op_b, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_operand, alu_result, rsp_ready,
    input  cmd_ready, alu_opcode, alu_op_a, alu_op_b, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_issuer.sv
// Accumulator-based issuer: feeds an external combinational ALU and returns the new accumulator.
// Optional macro ALU_ISSUER_DIVZERO_TRAP_EN rejects DIV/MOD by zero instead of issuing them.
module alu_issuer #(
  parameter int N = 32
) (
  input logic          clk,
  input logic          rst,
  alu_issuer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_MOD  = 4'd8;
  localparam logic [3:0] OP_LOAD = 4'd15;

  state_e       state_q;
  logic [N-1:0] acc_q;
  logic [3:0]   alu_opcode_q;
  logic [N-1:0] alu_op_a_q;
  logic [N-1:0] alu_op_b_q;
  logic         rsp_valid_q;
  logic [N-1:0] rsp_data_q;
  logic         rsp_err_q;

  logic div_zero;
  logic is_load;
  logic is_alu_op;

`ifdef ALU_ISSUER_DIVZERO_TRAP_EN
  assign div_zero = ((bus.cmd_opcode == OP_DIV) || (bus.cmd_opcode == OP_MOD)) &&
                    (bus.cmd_operand == '0);
`else
  assign div_zero = 1'b0;
`endif

  assign is_load   = (bus.cmd_opcode == OP_LOAD);
  assign is_alu_op = (bus.cmd_opcode <= OP_MOD) && !div_zero;

  // NOTE: state is written only with non-blocking assignments and cleared by the async reset;
  // blocking assignments here would create read-order races between the registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      alu_opcode_q <= '0;
      alu_op_a_q   <= '0;
      alu_op_b_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (is_alu_op) begin
              alu_opcode_q <= bus.cmd_opcode;
              alu_op_a_q   <= acc_q;
              alu_op_b_q   <= bus.cmd_operand;
              state_q      <= EXEC;
            end else if (is_load) begin
              acc_q       <= bus.cmd_operand;
              rsp_data_q  <= bus.cmd_operand;
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              // Illegal opcode or trapped divide: ALU untouched, accumulator echoed back.
              rsp_data_q  <= acc_q;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        EXEC: begin
          acc_q       <= bus.alu_result;
          rsp_data_q  <= bus.alu_result;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_op_a   = alu_op_a_q;
  assign bus.alu_op_b   = alu_op_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_issuer.sv
// Directed self-checking bench for alu_issuer with a behavioural external ALU.
module tb_alu_issuer;
  localparam int N = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] exp_acc;
  logic [3:0]  exp_op;
  logic [31:0] exp_a;
  logic [31:0] exp_b;

  alu_issuer_if #(.N(N)) bus ();

  alu_issuer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU. A divide by zero returns a recognisable marker value.
  always_comb begin
    bus.alu_result = '0;
    unique case (bus.alu_opcode)
      4'd0: bus.alu_result = bus.alu_op_a + bus.alu_op_b;
      4'd1: bus.alu_result = {31'd0, bus.alu_op_a < bus.alu_op_b};
      4'd2: bus.alu_result = {31'd0, bus.alu_op_a == bus.alu_op_b};
      4'd3: bus.alu_result = bus.alu_op_a | bus.alu_op_b;
      4'd4: bus.alu_result = bus.alu_op_a & bus.alu_op_b;
      4'd5: bus.alu_result = {31'd0, bus.alu_op_a == '0};
      4'd6: bus.alu_result = bus.alu_op_a * bus.alu_op_b;
      4'd7: bus.alu_result = (bus.alu_op_b == '0) ? 32'hDEAD_BEEF : bus.alu_op_a / bus.alu_op_b;
      4'd8: bus.alu_result = (bus.alu_op_b == '0) ? 32'hDEAD_BEEF : bus.alu_op_a % bus.alu_op_b;
      default: bus.alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command, check ALU issue, latency and response, then complete the handshake.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] operand,
                       input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
    int lat;
    @(negedge clk);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = op;
    bus.cmd_operand = operand;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (exp_lat == 2) begin
      exp_op = op;
      exp_a  = exp_acc;
      exp_b  = operand;
    end
    check({tag, "_alu_opcode"}, bus.alu_opcode, exp_op);
    check({tag, "_alu_op_a"}, bus.alu_op_a, exp_a);
    check({tag, "_alu_op_b"}, bus.alu_op_b, exp_b);
    lat = 1;
    while (!bus.rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rsp_data"}, bus.rsp_data, exp_data);
    check({tag, "_rsp_err"}, bus.rsp_err, exp_err);
    if (!exp_err) exp_acc = exp_data;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, bus.rsp_valid, 0);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    exp_acc         = '0;
    exp_op          = '0;
    exp_a           = '0;
    exp_b           = '0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_opcode  = '0;
    bus.cmd_operand = '0;
    bus.rsp_ready   = 1'b0;
    rst             = 1'b1;

    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_alu_opcode", bus.alu_opcode, 0);
    check("rst_alu_op_a", bus.alu_op_a, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // LOAD then ADD: latencies 1 and 2
    issue("load5", 4'd15, 32'd5, 1, 32'd5, 1'b0);
    issue("add7", 4'd0, 32'd7, 2, 32'd12, 1'b0);

    // Wrap-around and truncated multiply
    issue("load_max", 4'd15, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0);
    issue("add_wrap", 4'd0, 32'd1, 2, 32'd0, 1'b0);
    issue("load_msb", 4'd15, 32'h8000_0000, 1, 32'h8000_0000, 1'b0);
    issue("mul3", 4'd6, 32'd3, 2, 32'h8000_0000, 1'b0);
    issue("mul2", 4'd6, 32'd2, 2, 32'd0, 1'b0);

    // Illegal opcode then LESS
    issue("load9", 4'd15, 32'd9, 1, 32'd9, 1'b0);
    issue("illegal11", 4'd11, 32'd4, 1, 32'd9, 1'b1);
    issue("illegal14", 4'd14, 32'd0, 1, 32'd9, 1'b1);
    issue("less10", 4'd1, 32'd10, 2, 32'd1, 1'b0);

    // Bitwise and compare patterns
    issue("load_f0", 4'd15, 32'hF0, 1, 32'hF0, 1'b0);
    issue("or_0f", 4'd3, 32'h0F, 2, 32'hFF, 1'b0);
    issue("and_3c", 4'd4, 32'h3C, 2, 32'h3C, 1'b0);
    issue("eq_3c", 4'd2, 32'h3C, 2, 32'h1, 1'b0);
    issue("div_by3", 4'd7, 32'd3, 2, 32'd0, 1'b0);

    // Divide and modulo by zero
    issue("load20", 4'd15, 32'd20, 1, 32'd20, 1'b0);
`ifdef ALU_ISSUER_DIVZERO_TRAP_EN
    issue("div0", 4'd7, 32'd0, 1, 32'd20, 1'b1);
    issue("mod0", 4'd8, 32'd0, 1, 32'd20, 1'b1);
    issue("mod6", 4'd8, 32'd6, 2, 32'd2, 1'b0);
`else
    issue("div0", 4'd7, 32'd0, 2, 32'hDEAD_BEEF, 1'b0);
    issue("load20b", 4'd15, 32'd20, 1, 32'd20, 1'b0);
    issue("mod6", 4'd8, 32'd6, 2, 32'd2, 1'b0);
`endif

    // Backpressure: response held while a new command waits
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = 4'd15;
    bus.cmd_operand = 32'd42;
    @(posedge clk);
    #1;
    bus.cmd_opcode  = 4'd0;
    bus.cmd_operand = 32'd1;
    check("bp_rsp_valid", bus.rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", bus.rsp_valid, 1);
      check("bp_hold_data", bus.rsp_data, 32'd42);
      check("bp_hold_err", bus.rsp_err, 0);
      check("bp_hold_cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("bp_release_valid", bus.rsp_valid, 0);
    check("bp_release_cmd_ready", bus.cmd_ready, 1);
    check("bp_no_issue_opcode", bus.alu_opcode, exp_op);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("bp_accept_cmd_ready", bus.cmd_ready, 0);
    check("bp_accept_op_a", bus.alu_op_a, 32'd42);
    check("bp_accept_op_b", bus.alu_op_b, 32'd1);
    check("bp_accept_opcode", bus.alu_opcode, 4'd0);
    @(posedge clk);
    #1;
    check("bp_add_valid", bus.rsp_valid, 1);
    check("bp_add_data", bus.rsp_data, 32'd43);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    exp_acc = 32'd43;
    exp_op  = 4'd0;
    exp_a   = 32'd42;
    exp_b   = 32'd1;

    // Asynchronous reset in the middle of EXEC
    issue("load10", 4'd15, 32'd10, 1, 32'd10, 1'b0);
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = 4'd0;
    bus.cmd_operand = 32'd3;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("exec_cmd_ready", bus.cmd_ready, 0);
    check("exec_op_a", bus.alu_op_a, 32'd10);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", bus.rsp_valid, 0);
    check("arst_rsp_data", bus.rsp_data, 0);
    check("arst_alu_opcode", bus.alu_opcode, 0);
    check("arst_alu_op_a", bus.alu_op_a, 0);
    check("arst_alu_op_b", bus.alu_op_b, 0);
    check("arst_cmd_ready", bus.cmd_ready, 1);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("arst_no_rsp", bus.rsp_valid, 0);
      check("arst_idle_ready", bus.cmd_ready, 1);
    end
    exp_acc = '0;
    exp_op  = '0;
    exp_a   = '0;
    exp_b   = '0;
    issue("not0", 4'd5, 32'd0, 2, 32'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
